// File: rtl/packet_reference_table_if.sv
// PRT bus between the packet dealer (master) and the packet reference table (slave).
interface packet_reference_table_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_SLOTS  = 4,
   parameter int unsigned MAX_BYTES  = 1518
);
   localparam int unsigned SW = $clog2(NUM_SLOTS);

   logic                  EN_start_writing_prt_entry;
   logic                  RDY_start_writing_prt_entry;
   logic [SW-1:0]         start_writing_prt_entry;
   logic                  EN_write_prt_entry;
   logic                  RDY_write_prt_entry;
   logic [DATA_WIDTH-1:0] write_prt_entry_data;
   logic                  EN_finish_writing_prt_entry;
   logic                  RDY_finish_writing_prt_entry;
   logic                  EN_invalidate_prt_entry;
   logic                  RDY_invalidate_prt_entry;
   logic [SW-1:0]         invalidate_prt_entry_slot;
   logic                  EN_start_reading_prt_entry;
   logic                  RDY_start_reading_prt_entry;
   logic [SW-1:0]         start_reading_prt_entry_slot;
   logic                  EN_read_prt_entry;
   logic                  RDY_read_prt_entry;
   logic [DATA_WIDTH:0]   read_prt_entry;
   logic                  is_prt_slot_free;
   logic                  RDY_is_prt_slot_free;

   modport master (
      output EN_start_writing_prt_entry, EN_write_prt_entry, write_prt_entry_data,
             EN_finish_writing_prt_entry, EN_invalidate_prt_entry, invalidate_prt_entry_slot,
             EN_start_reading_prt_entry, start_reading_prt_entry_slot, EN_read_prt_entry,
      input  RDY_start_writing_prt_entry, start_writing_prt_entry, RDY_write_prt_entry,
             RDY_finish_writing_prt_entry, RDY_invalidate_prt_entry, RDY_start_reading_prt_entry,
             RDY_read_prt_entry, read_prt_entry, is_prt_slot_free, RDY_is_prt_slot_free
   );

   modport slave (
      input  EN_start_writing_prt_entry, EN_write_prt_entry, write_prt_entry_data,
             EN_finish_writing_prt_entry, EN_invalidate_prt_entry, invalidate_prt_entry_slot,
             EN_start_reading_prt_entry, start_reading_prt_entry_slot, EN_read_prt_entry,
      output RDY_start_writing_prt_entry, start_writing_prt_entry, RDY_write_prt_entry,
             RDY_finish_writing_prt_entry, RDY_invalidate_prt_entry, RDY_start_reading_prt_entry,
             RDY_read_prt_entry, read_prt_entry, is_prt_slot_free, RDY_is_prt_slot_free
   );
endinterface

// File: rtl/packet_reference_table.sv
// Packet reference table: NUM_SLOTS packet buffers with one write and one read
// transaction that may run concurrently on different slots.
module packet_reference_table #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_SLOTS  = 4,
   parameter int unsigned MAX_BYTES  = 1518
) (
   input logic                     CLK,
   input logic                     RST,
   packet_reference_table_if.slave bus
);
   localparam int unsigned SW = $clog2(NUM_SLOTS);
   localparam int unsigned CW = $clog2(MAX_BYTES + 1);

   typedef enum logic {WrIdle, WrActive} wr_state_e;
   typedef enum logic {RdIdle, RdActive} rd_state_e;

   logic [DATA_WIDTH-1:0] mem [NUM_SLOTS][MAX_BYTES];

   logic [NUM_SLOTS-1:0] valid_q, valid_d;
   logic [CW-1:0]        len_q [NUM_SLOTS];
   logic [CW-1:0]        len_d [NUM_SLOTS];
   wr_state_e            wr_state_q, wr_state_d;
   logic [SW-1:0]        wr_slot_q, wr_slot_d;
   logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
   rd_state_e            rd_state_q, rd_state_d;
   logic [SW-1:0]        rd_slot_q, rd_slot_d;
   logic [CW-1:0]        rd_ptr_q, rd_ptr_d;

   logic [NUM_SLOTS-1:0] free;
   logic [SW-1:0]        grant;
   logic                 any_free;
   logic rdy_start, rdy_write, rdy_finish, rdy_start_rd, rdy_read;
   logic start_fire, write_fire, finish_fire, start_rd_fire, read_fire, inv_fire;
   logic rd_last;

   // Free set and lowest-index grant from the current (pre-edge) state.
   always_comb begin
      free = ~valid_q;
      if (wr_state_q == WrActive) free[wr_slot_q] = 1'b0;
      grant = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (free[i]) grant = SW'(i);
      end
   end

   assign any_free     = |free;
   assign rdy_start    = !RST && (wr_state_q == WrIdle) && any_free;
   assign rdy_write    = !RST && (wr_state_q == WrActive) && (wr_cnt_q < CW'(MAX_BYTES));
   assign rdy_finish   = !RST && (wr_state_q == WrActive) && (wr_cnt_q != '0);
   assign rdy_start_rd = !RST && (rd_state_q == RdIdle);
   assign rdy_read     = !RST && (rd_state_q == RdActive);

   assign start_fire    = bus.EN_start_writing_prt_entry && rdy_start;
   assign write_fire    = bus.EN_write_prt_entry && rdy_write;
   assign finish_fire   = bus.EN_finish_writing_prt_entry && rdy_finish;
   assign start_rd_fire = bus.EN_start_reading_prt_entry && rdy_start_rd;
   assign read_fire     = bus.EN_read_prt_entry && rdy_read;
   // Invalidating the slot currently being written is ignored.
   assign inv_fire      = bus.EN_invalidate_prt_entry && !RST &&
                          !((wr_state_q == WrActive) &&
                            (bus.invalidate_prt_entry_slot == wr_slot_q));

   assign rd_last = (rd_ptr_q == len_q[rd_slot_q] - CW'(1));

   assign bus.RDY_start_writing_prt_entry  = rdy_start;
   assign bus.start_writing_prt_entry      = grant;
   assign bus.RDY_write_prt_entry          = rdy_write;
   assign bus.RDY_finish_writing_prt_entry = rdy_finish;
   assign bus.RDY_invalidate_prt_entry     = !RST;
   assign bus.RDY_start_reading_prt_entry  = rdy_start_rd;
   assign bus.RDY_read_prt_entry           = rdy_read;
   assign bus.read_prt_entry = rdy_read ? {rd_last, mem[rd_slot_q][rd_ptr_q]} : '0;
   assign bus.is_prt_slot_free             = !RST && any_free;
   assign bus.RDY_is_prt_slot_free         = !RST;

   // Next-state for slot table, write FSM and read FSM.
   always_comb begin
      valid_d    = valid_q;
      len_d      = len_q;
      wr_state_d = wr_state_q;
      wr_slot_d  = wr_slot_q;
      wr_cnt_d   = wr_cnt_q;
      rd_state_d = rd_state_q;
      rd_slot_d  = rd_slot_q;
      rd_ptr_d   = rd_ptr_q;

      if (start_fire) begin
         wr_state_d = WrActive;
         wr_slot_d  = grant;
         wr_cnt_d   = '0;
      end
      if (write_fire) wr_cnt_d = wr_cnt_q + CW'(1);
      if (finish_fire) begin
         valid_d[wr_slot_q] = 1'b1;
         len_d[wr_slot_q]   = wr_cnt_q + CW'(write_fire);
         wr_state_d         = WrIdle;
      end

      // Opening a read on an invalid slot is silently dropped.
      if (start_rd_fire && valid_q[bus.start_reading_prt_entry_slot]) begin
         rd_state_d = RdActive;
         rd_slot_d  = bus.start_reading_prt_entry_slot;
         rd_ptr_d   = '0;
      end
      if (read_fire) begin
         if (rd_last) rd_state_d = RdIdle;
         else         rd_ptr_d   = rd_ptr_q + CW'(1);
      end

      // Invalidate aborts any read on that slot, including one opening this cycle.
      if (inv_fire) begin
         valid_d[bus.invalidate_prt_entry_slot] = 1'b0;
         if ((rd_state_d == RdActive) && (rd_slot_d == bus.invalidate_prt_entry_slot)) begin
            rd_state_d = RdIdle;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q    <= '0;
         wr_state_q <= WrIdle;
         wr_slot_q  <= '0;
         wr_cnt_q   <= '0;
         rd_state_q <= RdIdle;
         rd_slot_q  <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
      end else begin
         valid_q    <= valid_d;
         len_q      <= len_d;
         wr_state_q <= wr_state_d;
         wr_slot_q  <= wr_slot_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_state_q <= rd_state_d;
         rd_slot_q  <= rd_slot_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Packet storage; not cleared by reset.
   always_ff @(posedge CLK) begin
      if (write_fire) mem[wr_slot_q][wr_cnt_q] <= bus.write_prt_entry_data;
   end
endmodule

// File: tb/tb_packet_reference_table.sv
// Self-checking bench: stimulus pushes expected read beats to a scoreboard,
// a monitor pops and compares each accepted beat.
module tb_packet_reference_table;
   localparam int unsigned DW   = 8;
   localparam int unsigned NS   = 4;
   localparam int unsigned MAXB = 1518;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   packet_reference_table_if #(.DATA_WIDTH(DW), .NUM_SLOTS(NS), .MAX_BYTES(MAXB)) bus ();

   packet_reference_table #(.DATA_WIDTH(DW), .NUM_SLOTS(NS), .MAX_BYTES(MAXB)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   logic [DW:0]   sb [$];
   logic [DW-1:0] mdl_mem [NS][MAXB];
   int            mdl_len [NS];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: compare every accepted read beat against the scoreboard head.
   always @(negedge CLK) begin
      if (!RST && bus.EN_read_prt_entry && bus.RDY_read_prt_entry) begin
         if (sb.size() == 0) begin
            check("read_unexpected", 32'(bus.read_prt_entry), 32'h0);
            n_pass = n_pass; // counted as a failure above only if beat nonzero
         end else begin
            check("read_beat", 32'(bus.read_prt_entry), 32'(sb.pop_front()));
         end
      end
   end

   task automatic write_pkt(input int slot, input int n, input logic [7:0] base,
                            input logic [7:0] step);
      logic [7:0] d;
      check("wr_rdy_start", 32'(bus.RDY_start_writing_prt_entry), 32'd1);
      check("wr_grant", 32'(bus.start_writing_prt_entry), 32'(slot));
      bus.EN_start_writing_prt_entry = 1'b1;
      tick();
      bus.EN_start_writing_prt_entry = 1'b0;
      for (int i = 0; i < n; i++) begin
         d = base + 8'(i) * step;
         mdl_mem[slot][i] = d;
         bus.EN_write_prt_entry   = 1'b1;
         bus.write_prt_entry_data = d;
         tick();
      end
      bus.EN_write_prt_entry = 1'b0;
      check("wr_rdy_write_after", 32'(bus.RDY_write_prt_entry), (n < int'(MAXB)) ? 32'd1 : 32'd0);
      if (n >= int'(MAXB)) begin
         // Extra beat on a full slot must be dropped.
         bus.EN_write_prt_entry   = 1'b1;
         bus.write_prt_entry_data = 8'hFF;
         tick();
         bus.EN_write_prt_entry = 1'b0;
      end
      check("wr_rdy_finish", 32'(bus.RDY_finish_writing_prt_entry), 32'd1);
      bus.EN_finish_writing_prt_entry = 1'b1;
      tick();
      bus.EN_finish_writing_prt_entry = 1'b0;
      mdl_len[slot] = n;
   endtask

   task automatic read_pkt(input int slot);
      check("rd_rdy_start", 32'(bus.RDY_start_reading_prt_entry), 32'd1);
      for (int i = 0; i < mdl_len[slot]; i++) sb.push_back({i == mdl_len[slot] - 1, mdl_mem[slot][i]});
      bus.EN_start_reading_prt_entry   = 1'b1;
      bus.start_reading_prt_entry_slot = 2'(slot);
      tick();
      bus.EN_start_reading_prt_entry = 1'b0;
      bus.EN_read_prt_entry          = 1'b1;
      repeat (mdl_len[slot]) tick();
      bus.EN_read_prt_entry = 1'b0;
      check("rd_rdy_after_last", 32'(bus.RDY_read_prt_entry), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.EN_start_writing_prt_entry   = 1'b0;
      bus.EN_write_prt_entry           = 1'b0;
      bus.write_prt_entry_data         = '0;
      bus.EN_finish_writing_prt_entry  = 1'b0;
      bus.EN_invalidate_prt_entry      = 1'b0;
      bus.invalidate_prt_entry_slot    = '0;
      bus.EN_start_reading_prt_entry   = 1'b0;
      bus.start_reading_prt_entry_slot = '0;
      bus.EN_read_prt_entry            = 1'b0;

      // Reset: outputs held low during reset, idle values after.
      RST = 1'b1;
      tick();
      check("rst_rdy_start_in_reset", 32'(bus.RDY_start_writing_prt_entry), 32'd0);
      check("rst_rdy_inv_in_reset", 32'(bus.RDY_invalidate_prt_entry), 32'd0);
      check("rst_read_in_reset", 32'(bus.read_prt_entry), 32'd0);
      tick();
      RST = 1'b0;
      #1;
      check("rst_is_free", 32'(bus.is_prt_slot_free), 32'd1);
      check("rst_rdy_start", 32'(bus.RDY_start_writing_prt_entry), 32'd1);
      check("rst_grant", 32'(bus.start_writing_prt_entry), 32'd0);
      check("rst_rdy_read", 32'(bus.RDY_read_prt_entry), 32'd0);
      check("rst_read_data", 32'(bus.read_prt_entry), 32'd0);
      check("rst_rdy_inv", 32'(bus.RDY_invalidate_prt_entry), 32'd1);
      check("rst_rdy_is_free", 32'(bus.RDY_is_prt_slot_free), 32'd1);
      tick();

      // Three-beat packet in slot 0: A1, B2, C3 -> beats 0x0A1, 0x0B2, 0x1C3.
      write_pkt(0, 3, 8'hA1, 8'h11);
      read_pkt(0);

      // Fill remaining slots, then free slot 2.
      write_pkt(1, 2, 8'h10, 8'h01);
      write_pkt(2, 2, 8'h20, 8'h01);
      write_pkt(3, 2, 8'h30, 8'h01);
      check("full_is_free", 32'(bus.is_prt_slot_free), 32'd0);
      check("full_rdy_start", 32'(bus.RDY_start_writing_prt_entry), 32'd0);
      bus.EN_invalidate_prt_entry   = 1'b1;
      bus.invalidate_prt_entry_slot = 2'd2;
      tick();
      bus.EN_invalidate_prt_entry = 1'b0;
      check("inv2_is_free", 32'(bus.is_prt_slot_free), 32'd1);
      check("inv2_grant", 32'(bus.start_writing_prt_entry), 32'd2);

      // Maximum-length packet into slot 2.
      write_pkt(2, int'(MAXB), 8'h00, 8'h01);
      read_pkt(2);

      // Read slot 1 while writing slot 3; invalidate slot 1 mid-read.
      bus.EN_invalidate_prt_entry   = 1'b1;
      bus.invalidate_prt_entry_slot = 2'd3;
      tick();
      bus.EN_invalidate_prt_entry = 1'b0;
      check("cc_grant", 32'(bus.start_writing_prt_entry), 32'd3);
      bus.EN_start_reading_prt_entry   = 1'b1;
      bus.start_reading_prt_entry_slot = 2'd1;
      bus.EN_start_writing_prt_entry   = 1'b1;
      tick();
      bus.EN_start_reading_prt_entry = 1'b0;
      bus.EN_start_writing_prt_entry = 1'b0;
      check("cc_rdy_read", 32'(bus.RDY_read_prt_entry), 32'd1);
      sb.push_back(9'h010);
      bus.EN_read_prt_entry    = 1'b1;
      bus.EN_write_prt_entry   = 1'b1;
      bus.write_prt_entry_data = 8'h31;
      tick();
      bus.EN_read_prt_entry         = 1'b0;
      bus.EN_invalidate_prt_entry   = 1'b1;
      bus.invalidate_prt_entry_slot = 2'd1;
      bus.write_prt_entry_data      = 8'h32;
      tick();
      bus.EN_invalidate_prt_entry = 1'b0;
      check("cc_read_aborted", 32'(bus.RDY_read_prt_entry), 32'd0);
      bus.write_prt_entry_data = 8'h33;
      tick();
      bus.EN_write_prt_entry          = 1'b0;
      bus.EN_finish_writing_prt_entry = 1'b1;
      tick();
      bus.EN_finish_writing_prt_entry = 1'b0;
      mdl_mem[3][0] = 8'h31;
      mdl_mem[3][1] = 8'h32;
      mdl_mem[3][2] = 8'h33;
      mdl_len[3]    = 3;
      check("cc_grant_after", 32'(bus.start_writing_prt_entry), 32'd1);
      read_pkt(3);

      // Reset in the middle of a write to slot 1.
      bus.EN_start_writing_prt_entry = 1'b1;
      tick();
      bus.EN_start_writing_prt_entry = 1'b0;
      bus.EN_write_prt_entry         = 1'b1;
      bus.write_prt_entry_data       = 8'h77;
      tick();
      tick();
      bus.EN_write_prt_entry = 1'b0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      #1;
      check("mrst_is_free", 32'(bus.is_prt_slot_free), 32'd1);
      check("mrst_grant", 32'(bus.start_writing_prt_entry), 32'd0);
      check("mrst_rdy_start", 32'(bus.RDY_start_writing_prt_entry), 32'd1);
      check("mrst_rdy_write", 32'(bus.RDY_write_prt_entry), 32'd0);
      check("mrst_rdy_finish", 32'(bus.RDY_finish_writing_prt_entry), 32'd0);
      for (int s = 0; s < int'(NS); s++) begin
         bus.EN_start_reading_prt_entry   = 1'b1;
         bus.start_reading_prt_entry_slot = 2'(s);
         tick();
         bus.EN_start_reading_prt_entry = 1'b0;
         check("mrst_slot_invalid", 32'(bus.RDY_read_prt_entry), 32'd0);
      end

      tick();
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
